ofs_fim_pcie_hdr_merge: RTL

- Inverse of the PCIe SS header-extraction stage.
- Takes an out-of-band header stream plus a bus-aligned payload stream and rebuilds the in-band PCIe SS TLP stream: header at tdata[0] of the SOP beat, payload shifted up by HDR_WIDTH.
- Sits on the TX path between AFU-side logic (which works on separate header and data channels) and the PCIe SS TX AXI-S port.

---
 rtl/ofs_fim_pcie_hdr_merge.sv | 131 +++++++++++++
 1 files changed

// File: rtl/ofs_fim_pcie_hdr_merge.sv
// rtl/ofs_fim_pcie_hdr_merge.sv - merges out-of-band PCIe SS header and payload streams into an in-band TLP stream
module ofs_fim_pcie_hdr_merge #(
    parameter int TDATA_WIDTH  = 512,
    parameter int HDR_WIDTH    = 256,
    parameter int TUSER_WIDTH  = 10,
    parameter int HAS_DATA_BIT = 30
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     hdr_tvalid,
    output logic                     hdr_tready,
    input  logic [TDATA_WIDTH-1:0]   hdr_tdata,
    input  logic [TUSER_WIDTH-1:0]   hdr_tuser_vendor,
    input  logic                     data_tvalid,
    output logic                     data_tready,
    input  logic [TDATA_WIDTH-1:0]   data_tdata,
    input  logic [TDATA_WIDTH/8-1:0] data_tkeep,
    input  logic                     data_tlast,
    output logic                     out_tvalid,
    input  logic                     out_tready,
    output logic [TDATA_WIDTH-1:0]   out_tdata,
    output logic [TDATA_WIDTH/8-1:0] out_tkeep,
    output logic                     out_tlast,
    output logic [TUSER_WIDTH-1:0]   out_tuser_vendor
);
    localparam int H  = HDR_WIDTH;
    localparam int HK = H / 8;
    localparam int A  = TDATA_WIDTH - H;
    localparam int AK = A / 8;
    localparam int KW = TDATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, BODY, DRAIN} state_t;

    state_t                 state_q, state_d;
    logic                   out_tvalid_q, out_tvalid_d;
    logic [TDATA_WIDTH-1:0] out_tdata_q, out_tdata_d;
    logic [KW-1:0]          out_tkeep_q, out_tkeep_d;
    logic                   out_tlast_q, out_tlast_d;
    logic [TUSER_WIDTH-1:0] out_tuser_q, out_tuser_d;
    logic [H-1:0]           prev_hi_q, prev_hi_d;
    logic [HK-1:0]          prev_hi_keep_q, prev_hi_keep_d;

    logic ld, has_data, hdr_pop, data_pop, in_idle;
    logic unused_hdr_hi;

    assign unused_hdr_hi = &{1'b0, hdr_tdata[TDATA_WIDTH-1:H]};

    always_comb begin
        ld       = !out_tvalid_q || out_tready;
        in_idle  = (state_q == IDLE);
        has_data = hdr_tdata[HAS_DATA_BIT];
        // Header and its first payload beat must be popped together.
        hdr_pop  = rst_n && ld && in_idle && hdr_tvalid && (!has_data || data_tvalid);
        data_pop = rst_n && ld && data_tvalid &&
                   ((in_idle && hdr_tvalid && has_data) || (state_q == BODY));

        state_d        = state_q;
        out_tvalid_d   = out_tvalid_q;
        out_tdata_d    = out_tdata_q;
        out_tkeep_d    = out_tkeep_q;
        out_tlast_d    = out_tlast_q;
        out_tuser_d    = out_tuser_q;
        prev_hi_d      = prev_hi_q;
        prev_hi_keep_d = prev_hi_keep_q;

        if (ld) begin
            out_tvalid_d = 1'b0;
        end

        if (ld && state_q == DRAIN) begin
            out_tvalid_d = 1'b1;
            out_tdata_d  = {{A{1'b0}}, prev_hi_q};
            out_tkeep_d  = {{AK{1'b0}}, prev_hi_keep_q};
            out_tlast_d  = 1'b1;
            out_tuser_d  = '0;
            state_d      = IDLE;
        end else if (hdr_pop && !has_data) begin
            out_tvalid_d = 1'b1;
            out_tdata_d  = {{A{1'b0}}, hdr_tdata[H-1:0]};
            out_tkeep_d  = {{AK{1'b0}}, {HK{1'b1}}};
            out_tlast_d  = 1'b1;
            out_tuser_d  = hdr_tuser_vendor;
        end else if (data_pop) begin
            out_tvalid_d   = 1'b1;
            out_tdata_d    = {data_tdata[A-1:0], in_idle ? hdr_tdata[H-1:0] : prev_hi_q};
            out_tkeep_d    = {data_tkeep[AK-1:0], in_idle ? {HK{1'b1}} : prev_hi_keep_q};
            out_tuser_d    = in_idle ? hdr_tuser_vendor : '0;
            prev_hi_d      = data_tdata[TDATA_WIDTH-1:A];
            prev_hi_keep_d = data_tkeep[KW-1:AK];
            // Upper half occupied on the last beat needs one extra drain beat.
            out_tlast_d    = data_tlast && !data_tkeep[AK];
            if (!data_tlast) begin
                state_d = BODY;
            end else if (data_tkeep[AK]) begin
                state_d = DRAIN;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            out_tvalid_q   <= 1'b0;
            out_tdata_q    <= '0;
            out_tkeep_q    <= '0;
            out_tlast_q    <= 1'b0;
            out_tuser_q    <= '0;
            prev_hi_q      <= '0;
            prev_hi_keep_q <= '0;
        end else begin
            state_q        <= state_d;
            out_tvalid_q   <= out_tvalid_d;
            out_tdata_q    <= out_tdata_d;
            out_tkeep_q    <= out_tkeep_d;
            out_tlast_q    <= out_tlast_d;
            out_tuser_q    <= out_tuser_d;
            prev_hi_q      <= prev_hi_d;
            prev_hi_keep_q <= prev_hi_keep_d;
        end
    end

    assign hdr_tready       = hdr_pop;
    assign data_tready      = data_pop;
    assign out_tvalid       = out_tvalid_q;
    assign out_tdata        = out_tdata_q;
    assign out_tkeep        = out_tkeep_q;
    assign out_tlast        = out_tlast_q;
    assign out_tuser_vendor = out_tuser_q;
endmodule
